bcd_conv_arbiter: RTL



---
 rtl/bcd_conv_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between NUM_REQ
// requesters, with a WAIT timeout so a stuck converter cannot hang anyone.
module bcd_conv_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned BIN_WIDTH      = 8,
    parameter int unsigned DEC_DIGITS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*BIN_WIDTH-1:0]   ReqData,
    output logic [NUM_REQ-1:0]             Ack,
    output logic [NUM_REQ-1:0]             RespValid,
    output logic [DEC_DIGITS*4-1:0]        RespBCD,
    output logic                           RespErr,
    output logic                           Busy,
    output logic [BIN_WIDTH-1:0]           ConvDataBin,
    output logic                           ConvStart,
    input  logic [DEC_DIGITS*4-1:0]        ConvDataBCD,
    input  logic                           ConvDone
);

    localparam int unsigned BCD_W = DEC_DIGITS * 4;
    localparam int unsigned GNT_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   grant_q, grant_d;
    logic [GNT_W-1:0]   last_grant_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q;

    logic               arb_valid;
    logic [GNT_W-1:0]   arb_idx;
    logic               done_edge;
    logic               timeout_hit;

    logic [NUM_REQ-1:0]   ack_d;
    logic [NUM_REQ-1:0]   resp_valid_d;
    logic [BCD_W-1:0]     resp_bcd_d;
    logic                 resp_err_d;
    logic                 busy_d;
    logic [BIN_WIDTH-1:0] conv_bin_d;
    logic                 conv_start_d;

    // Only a fresh rising edge of Done counts; a level left over from the
    // previous conversion is ignored.
    assign done_edge   = ConvDone & ~done_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Circular search for the first request after the last served requester.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(last_grant_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!arb_valid && Req[GNT_W'(idx)]) begin
                arb_valid = 1'b1;
                arb_idx   = GNT_W'(idx);
            end
        end
    end

    // State, grant, timeout counter and Done history registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GNT_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            done_q  <= ConvDone;
            if (state_q == S_RESP) begin
                last_grant_q <= grant_q;
            end
        end
    end

    // Next-state logic: arbitrate, pulse start, wait for Done or timeout, respond.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_edge || timeout_hit) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the transition being taken.
    always_comb begin
        ack_d        = '0;
        resp_valid_d = '0;
        resp_bcd_d   = '0;
        resp_err_d   = 1'b0;
        conv_start_d = 1'b0;
        conv_bin_d   = ConvDataBin;
        busy_d       = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    ack_d[arb_idx] = 1'b1;
                    conv_start_d   = 1'b1;
                    conv_bin_d     = ReqData[32'(arb_idx) * BIN_WIDTH +: BIN_WIDTH];
                end
            end
            S_WAIT: begin
                // A Done edge in the timeout cycle still wins.
                if (done_edge) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_bcd_d            = ConvDataBCD;
                end else if (timeout_hit) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_err_d            = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Ack         <= '0;
            RespValid   <= '0;
            RespBCD     <= '0;
            RespErr     <= 1'b0;
            Busy        <= 1'b0;
            ConvDataBin <= '0;
            ConvStart   <= 1'b0;
        end else begin
            Ack         <= ack_d;
            RespValid   <= resp_valid_d;
            RespBCD     <= resp_bcd_d;
            RespErr     <= resp_err_d;
            Busy        <= busy_d;
            ConvDataBin <= conv_bin_d;
            ConvStart   <= conv_start_d;
        end
    end

endmodule
